// File: rtl/stepper_pos_ctrl.sv
// Trapezoidal-profile position scheduler for a 2-phase stepper: 8-bit target in, coil phase/enable out.
// Optional build macro STEPPER_HOLD_EN keeps the coils energised in IDLE once the first move has started.
module stepper_pos_ctrl #(
  parameter int TICK_DIV     = 1024,
  parameter int MAX_PER      = 64,
  parameter int MIN_PER      = 8,
  parameter int ACC          = 4,
  parameter int DEADBAND     = 1,
  parameter int SETTLE_TICKS = 256
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [7:0] target,
  input  logic       target_valid,
  input  logic       enable,
  output logic [1:0] phase,
  output logic       coil_en,
  output logic       dir,
  output logic       step,
  output logic [7:0] pos,
  output logic       busy,
  output logic       at_target,
  output logic [2:0] dbg_state
);
  localparam int RAMP_MAX = (MAX_PER - MIN_PER) / ACC;
  localparam int DW = $clog2(TICK_DIV);
  localparam int PW = $clog2(MAX_PER + ACC + 1);
  localparam int RW = $clog2(RAMP_MAX + 2);
  localparam int SW = $clog2(SETTLE_TICKS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [PW-1:0] P_MAX    = PW'(MAX_PER);
  localparam logic [PW-1:0] P_MIN    = PW'(MIN_PER);
  localparam logic [PW-1:0] P_ACC    = PW'(ACC);
  localparam logic [PW-1:0] P_ONE    = PW'(1);
  localparam logic [SW-1:0] S_LAST   = SW'(SETTLE_TICKS - 1);
  localparam logic [7:0]    DB       = 8'(DEADBAND);

  typedef enum logic [2:0] {S_IDLE, S_ACCEL, S_CRUISE, S_DECEL, S_SETTLE} state_t;

  state_t        r_state, w_nxt;
  logic [DW-1:0] r_presc;
  logic [PW-1:0] r_cnt, r_per;
  logic [RW-1:0] r_ramp;
  logic [SW-1:0] r_settle;
  logic [7:0]    r_pos, r_tgt, w_rem, w_ramp8;
  logic [1:0]    r_phase, w_phase_nxt;
  logic          r_dir, r_step;
  logic          w_tick, w_moving, w_opp, w_expire, w_step;

  assign w_tick   = (r_presc == DIV_LAST);
  assign w_rem    = (r_tgt >= r_pos) ? (r_tgt - r_pos) : (r_pos - r_tgt);
  assign w_ramp8  = 8'(r_ramp);
  assign w_opp    = r_dir ? (r_tgt < r_pos) : (r_tgt > r_pos);
  assign w_moving = (r_state == S_ACCEL) || (r_state == S_CRUISE) || (r_state == S_DECEL);
  assign w_expire = w_moving && w_tick && ((r_cnt + P_ONE) == r_per);
  // An expired interval only moves the shaft toward the target; with the target
  // behind us the interval still elapses so the ramp winds down in place.
  assign w_step   = w_expire && (w_rem != 8'd0) && !w_opp;
  assign w_phase_nxt = r_dir ? {r_phase[0], ~r_phase[1]} : {~r_phase[0], r_phase[1]};

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   if (enable && (w_rem > DB)) w_nxt = S_ACCEL;
      S_ACCEL: begin
        if (w_rem == 8'd0)                              w_nxt = S_SETTLE;
        else if ((w_rem <= w_ramp8) || w_opp || !enable) w_nxt = S_DECEL;
        else if (r_per == P_MIN)                        w_nxt = S_CRUISE;
      end
      S_CRUISE: begin
        if (w_rem == 8'd0)                              w_nxt = S_SETTLE;
        else if ((w_rem <= w_ramp8) || w_opp || !enable) w_nxt = S_DECEL;
      end
      S_DECEL: begin
        if (w_rem == 8'd0)                                   w_nxt = S_SETTLE;
        else if (r_ramp == '0)                               w_nxt = enable ? S_ACCEL : S_SETTLE;
        else if (enable && !w_opp && (w_rem > w_ramp8))      w_nxt = S_ACCEL;
      end
      S_SETTLE: if (w_tick && (r_settle == S_LAST)) w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= S_IDLE;
      r_presc  <= '0;
      r_cnt    <= '0;
      r_per    <= P_MAX;
      r_ramp   <= '0;
      r_settle <= '0;
      r_pos    <= 8'd0;
      r_tgt    <= 8'd0;
      r_phase  <= 2'b00;
      r_dir    <= 1'b0;
      r_step   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_step  <= w_step;
      r_presc <= w_tick ? '0 : (r_presc + DW'(1));
      if (target_valid) r_tgt <= target;
      if (w_step) begin
        r_pos   <= r_dir ? (r_pos + 8'd1) : (r_pos - 8'd1);
        r_phase <= w_phase_nxt;
      end
      if (w_moving && w_tick) r_cnt <= w_expire ? '0 : (r_cnt + P_ONE);
      if (w_expire) begin
        case (r_state)
          S_ACCEL: if (w_step && (r_per > P_MIN)) begin
            r_per  <= r_per - P_ACC;
            r_ramp <= r_ramp + RW'(1);
          end
          S_DECEL: begin
            r_per <= ((r_per + P_ACC) >= P_MAX) ? P_MAX : (r_per + P_ACC);
            if (r_ramp != '0) r_ramp <= r_ramp - RW'(1);
          end
          default: ;
        endcase
      end
      if ((r_state == S_IDLE) && (w_nxt == S_ACCEL)) begin
        r_dir  <= (r_tgt > r_pos);
        r_per  <= P_MAX;
        r_ramp <= '0;
        r_cnt  <= '0;
      end
      // Reversal: direction flips only once the ramp has fully unwound.
      if ((r_state == S_DECEL) && (w_nxt == S_ACCEL) && w_opp) r_dir <= ~r_dir;
      if ((w_nxt == S_SETTLE) && (r_state != S_SETTLE)) r_settle <= '0;
      else if ((r_state == S_SETTLE) && w_tick)         r_settle <= r_settle + SW'(1);
    end
  end

`ifdef STEPPER_HOLD_EN
  logic r_held;
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N)               r_held <= 1'b0;
    else if (r_state != S_IDLE) r_held <= 1'b1;
  end
  assign coil_en = (r_state != S_IDLE) || r_held;
`else
  assign coil_en = (r_state != S_IDLE);
`endif

  assign phase     = r_phase;
  assign dir       = r_dir;
  assign step      = r_step;
  assign pos       = r_pos;
  assign busy      = (r_state != S_IDLE);
  assign at_target = (r_pos == r_tgt);
  assign dbg_state = r_state;
endmodule

// File: tb/tb_stepper_pos_ctrl.sv
// Directed bench for stepper_pos_ctrl at TICK_DIV=4: reset, short and long moves, deadband,
// async reset mid-move, reversal and enable drop, with a per-step position/phase/interval model.
module tb_stepper_pos_ctrl;
  localparam int TDIV = 4;
`ifdef STEPPER_HOLD_EN
  localparam logic HOLD = 1'b1;
`else
  localparam logic HOLD = 1'b0;
`endif

  logic       clk, rst_n;
  logic [7:0] target;
  logic       target_valid, enable;
  logic [1:0] phase;
  logic       coil_en, dir, step, busy, at_target;
  logic [7:0] pos;
  logic [2:0] dbg_state;

  int n_tests, n_fail, cyc;
  logic [31:0] exp_q[$];
  int m_pos, m_tgt, m_tgt_used, s_cnt, last_step_cyc, decel_pos, fall_cyc;
  bit last_valid, seen_cruise, seen_decel, saw_busy;
  logic mon_dir;

  stepper_pos_ctrl #(.TICK_DIV(TDIV)) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .target(target), .target_valid(target_valid),
    .enable(enable), .phase(phase), .coil_en(coil_en), .dir(dir), .step(step),
    .pos(pos), .busy(busy), .at_target(at_target), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] ph_of(input int p);
    case (p & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // target latch model: the step at an edge uses the target held before that edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tgt      <= 0;
      m_tgt_used <= 0;
    end else begin
      m_tgt_used <= m_tgt;
      if (target_valid) m_tgt <= int'(target);
    end
  end

  // scoreboard: every step must head toward the target with the next phase code
  always @(negedge clk) begin
    if (rst_n && step) begin
      mon_dir = (m_tgt_used > m_pos) ? 1'b1 : 1'b0;
      m_pos   = mon_dir ? m_pos + 1 : m_pos - 1;
      s_cnt++;
      check("step_dir", 32'(dir), 32'(mon_dir));
      check("step_pos", 32'(pos), 32'(m_pos));
      check("step_phase", 32'(phase), 32'(ph_of(m_pos)));
      if (last_valid && exp_q.size() > 0)
        check("step_interval", 32'(cyc - last_step_cyc), exp_q.pop_front());
      last_valid    = 1'b1;
      last_step_cyc = cyc;
    end
    if (rst_n && dbg_state == 3'd2) seen_cruise = 1'b1;
    if (rst_n && dbg_state == 3'd3 && !seen_decel) begin
      seen_decel = 1'b1;
      decel_pos  = int'(pos);
    end
  end

  // driver tasks
  task automatic do_reset();
    rst_n = 1'b0;
    target_valid = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    m_pos = 0; s_cnt = 0; last_valid = 1'b0;
    seen_cruise = 1'b0; seen_decel = 1'b0; decel_pos = -1;
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_target(input logic [7:0] v);
    @(negedge clk);
    target = v;
    target_valid = 1'b1;
    @(negedge clk);
    target_valid = 1'b0;
  endtask

  task automatic wait_pos(input int p, input int budget, input string tag);
    int n;
    n = 0;
    while (int'(pos) != p && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(int'(pos) == p), 32'd1);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (!busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    fall_cyc = cyc;
    check(tag, 32'(!busy), 32'd1);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    target = 8'd0;
    do_reset();

    // reset state
    check("rst_pos", 32'(pos), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_coil_en", 32'(coil_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_at_target", 32'(at_target), 32'd1);
    check("rst_step", 32'(step), 32'd0);
    check("rst_dir", 32'(dir), 32'd0);

    // short move: intervals 64,60,56 ticks, then 256-tick settle
    exp_q.push_back(32'(60 * TDIV));
    exp_q.push_back(32'(56 * TDIV));
    send_target(8'd3);
    wait_pos(3, 2000, "t2_reach");
    check("t2_settle_coil", 32'(coil_en), 32'd1);
    check("t2_settle_busy", 32'(busy), 32'd1);
    wait_done(3000, "t2_done");
    check("t2_pos", 32'(pos), 32'd3);
    check("t2_steps", 32'(s_cnt), 32'd3);
    check("t2_phase", 32'(phase), 32'(2'b10));
    check("t2_dir", 32'(dir), 32'd1);
    check("t2_settle_len", 32'((fall_cyc - last_step_cyc) >= 1020 && (fall_cyc - last_step_cyc) <= 1028), 32'd1);
    check("t2_intervals_left", 32'(exp_q.size()), 32'd0);
    check("t2_at_target", 32'(at_target), 32'd1);
    check("t2_idle_coil", 32'(coil_en), 32'(HOLD));

    // deadband: one count away starts nothing
    do_reset();
    send_target(8'd1);
    saw_busy = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    check("t3_busy", 32'(saw_busy), 32'd0);
    check("t3_steps", 32'(s_cnt), 32'd0);
    check("t3_at_target", 32'(at_target), 32'd0);

    // async reset mid-move
    send_target(8'd50);
    wait_pos(5, 3000, "t4_reach");
    #2 rst_n = 1'b0;
    #1;
    check("t4_pos", 32'(pos), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_coil_en", 32'(coil_en), 32'd0);
    check("t4_phase", 32'(phase), 32'd0);
    check("t4_step", 32'(step), 32'd0);

    // long move: accel 14 steps to per 8, cruise, decel at rem 14
    do_reset();
    for (int k = 1; k <= 99; k++) begin
      int p;
      if (k <= 13)      p = 64 - 4 * k;
      else if (k <= 86) p = 8;
      else              p = 8 + 4 * (k - 86);
      exp_q.push_back(32'(p * TDIV));
    end
    send_target(8'd100);
    wait_done(12000, "t5_done");
    check("t5_pos", 32'(pos), 32'd100);
    check("t5_phase", 32'(phase), 32'd0);
    check("t5_steps", 32'(s_cnt), 32'd100);
    check("t5_cruise", 32'(seen_cruise), 32'd1);
    check("t5_decel_pos", 32'(decel_pos), 32'd86);
    check("t5_intervals_left", 32'(exp_q.size()), 32'd0);
    check("t5_at_target", 32'(at_target), 32'd1);

    // reversal: out to 40, then back to 10 without overshoot
    do_reset();
    send_target(8'd200);
    wait_pos(40, 6000, "t6_reach");
    send_target(8'd10);
    wait_done(20000, "t6_done");
    check("t6_pos", 32'(pos), 32'd10);
    check("t6_dir", 32'(dir), 32'd0);
    check("t6_steps", 32'(s_cnt), 32'd70);
    check("t6_phase", 32'(phase), 32'(2'b11));
    check("t6_at_target", 32'(at_target), 32'd1);

    // enable drop during cruise: 14 decel steps from 30, stop at 44
    do_reset();
    send_target(8'd100);
    wait_pos(30, 5000, "t7_reach");
    enable = 1'b0;
    wait_done(12000, "t7_done");
    check("t7_pos", 32'(pos), 32'd44);
    check("t7_at_target", 32'(at_target), 32'd0);
    check("t7_coil_en", 32'(coil_en), 32'(HOLD));
    saw_busy = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    check("t7_blocked", 32'(saw_busy), 32'd0);
    enable = 1'b1;
    wait_done(12000, "t7_resume_done");
    check("t7_resume_pos", 32'(pos), 32'd100);
    check("t7_resume_phase", 32'(phase), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
